// File: rtl/ram_test_pkg.sv
// Shared definitions for the RAM test blocks: checker FSM encoding and the
// default data/address/counter widths also used by the pattern generator.
package ram_test_pkg;

    localparam int DEF_D_WIDTH = 8;
    localparam int DEF_A_WIDTH = 10;
    localparam int DEF_C_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chk_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset, synchronous clear and
// increment enable; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_srst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/ram_data_checker.sv
// Compares RAM readback against expected words over a start..last run,
// counting words and mismatches and capturing the first failing word.
// Optional RAM_CHECK_MASK_EN adds i_mask to exclude bits from the compare.
module ram_data_checker
    import ram_test_pkg::*;
#(
    parameter int D_WIDTH = DEF_D_WIDTH,
    parameter int A_WIDTH = DEF_A_WIDTH,
    parameter int C_WIDTH = DEF_C_WIDTH
) (
    input  logic               i_clk,
    input  logic               i_arst,
    input  logic               i_start,
    input  logic               i_vld,
    input  logic [D_WIDTH-1:0] i_exp_d,
    input  logic [D_WIDTH-1:0] i_rd_d,
    input  logic [A_WIDTH-1:0] i_addr,
    input  logic               i_last,
`ifdef RAM_CHECK_MASK_EN
    input  logic [D_WIDTH-1:0] i_mask,
`endif
    output logic               o_busy,
    output logic               o_done,
    output logic               o_pass,
    output logic [C_WIDTH-1:0] o_err_cnt,
    output logic [C_WIDTH-1:0] o_word_cnt,
    output logic [A_WIDTH-1:0] o_ferr_addr,
    output logic [D_WIDTH-1:0] o_ferr_exp,
    output logic [D_WIDTH-1:0] o_ferr_got
);

    chk_state_e         state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [A_WIDTH-1:0] ferr_addr_q, ferr_addr_d;
    logic [D_WIDTH-1:0] ferr_exp_q, ferr_exp_d;
    logic [D_WIDTH-1:0] ferr_got_q, ferr_got_d;

    logic [D_WIDTH-1:0] diff;
    logic               mismatch;
    logic               accept_word;
    logic               start_ok;
    logic [C_WIDTH-1:0] err_cnt;
    logic [C_WIDTH-1:0] word_cnt;

`ifdef RAM_CHECK_MASK_EN
    assign diff = (i_exp_d ^ i_rd_d) & ~i_mask;
`else
    assign diff = i_exp_d ^ i_rd_d;
`endif

    assign mismatch    = |diff;
    assign accept_word = (state_q == ST_RUN) && i_vld;
    assign start_ok    = i_start && (state_q != ST_RUN);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (i_start)          state_d = ST_RUN;
            ST_RUN:  if (i_vld && i_last)  state_d = ST_DONE;
            ST_DONE: if (i_start)          state_d = ST_RUN;
            default:                       state_d = ST_IDLE;
        endcase
    end

    // The error counter saturates and never returns to zero within a run,
    // so zero reliably means "no mismatch captured yet".
    always_comb begin
        ferr_addr_d = ferr_addr_q;
        ferr_exp_d  = ferr_exp_q;
        ferr_got_d  = ferr_got_q;
        if (start_ok) begin
            ferr_addr_d = '0;
            ferr_exp_d  = '0;
            ferr_got_d  = '0;
        end else if (accept_word && mismatch && (err_cnt == '0)) begin
            ferr_addr_d = i_addr;
            ferr_exp_d  = i_exp_d;
            ferr_got_d  = i_rd_d;
        end
    end

    // Pass folds in the word being sampled so the last word counts on entry to DONE.
    always_comb begin
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
        pass_d = (state_d == ST_DONE) && (err_cnt == '0) && !(accept_word && mismatch);
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            ferr_addr_q <= '0;
            ferr_exp_q  <= '0;
            ferr_got_q  <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            ferr_addr_q <= ferr_addr_d;
            ferr_exp_q  <= ferr_exp_d;
            ferr_got_q  <= ferr_got_d;
        end
    end

    sat_counter #(.WIDTH(C_WIDTH)) u_err_cnt (
        .i_clk  (i_clk),
        .i_srst (i_arst),
        .i_clr  (start_ok),
        .i_inc  (accept_word && mismatch),
        .o_cnt  (err_cnt)
    );

    sat_counter #(.WIDTH(C_WIDTH)) u_word_cnt (
        .i_clk  (i_clk),
        .i_srst (i_arst),
        .i_clr  (start_ok),
        .i_inc  (accept_word),
        .o_cnt  (word_cnt)
    );

    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_pass      = pass_q;
    assign o_err_cnt   = err_cnt;
    assign o_word_cnt  = word_cnt;
    assign o_ferr_addr = ferr_addr_q;
    assign o_ferr_exp  = ferr_exp_q;
    assign o_ferr_got  = ferr_got_q;

endmodule
